// File: rtl/perf_pkg.sv
// Shared definitions for the pipeline performance monitor: state encoding,
// readout select map and a width helper.
package perf_pkg;

    typedef enum logic [1:0] {
        PM_RUN   = 2'd0,
        PM_DRAIN = 2'd1,
        PM_DONE  = 2'd2
    } pm_state_e;

    localparam int unsigned SEL_INST    = 0;
    localparam int unsigned SEL_TOTAL   = 1;
    localparam int unsigned SEL_EV_BASE = 2;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((32'd1 << r) < n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Single performance counter: increment with saturate or wrap, parallel load,
// synchronous clear and a sticky overflow flag.
module perf_counter #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned INC_WIDTH = 3,
    parameter int unsigned SATURATE  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [INC_WIDTH-1:0] inc,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] count_next,
    output logic                 overflow
);

    localparam int unsigned SUM_WIDTH = ((INC_WIDTH > CNT_WIDTH) ? INC_WIDTH : CNT_WIDTH) + 1;

    logic [CNT_WIDTH-1:0] count_q;
    logic                 ovf_q;
    logic                 ovf_d;
    logic [SUM_WIDTH-1:0] sum;
    logic                 carry;

    always_comb begin
        sum        = SUM_WIDTH'(count_q) + SUM_WIDTH'(inc);
        carry      = |sum[SUM_WIDTH-1:CNT_WIDTH];
        count_next = count_q;
        ovf_d      = ovf_q;
        if (clear) begin
            count_next = '0;
            ovf_d      = 1'b0;
        end else if (load) begin
            count_next = load_val;
        end else if (enable) begin
            if (carry) begin
                ovf_d      = 1'b1;
                count_next = (SATURATE != 0) ? '1 : sum[CNT_WIDTH-1:0];
            end else begin
                count_next = sum[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_next;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: instruction tick counter, weighted event
// channels, completion freeze with drain correction and a snapshot readout.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int unsigned NUM_EVENTS   = 4,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned WEIGHT_WIDTH = 3,
    parameter int unsigned DRAIN_ADJ    = 4,
    parameter int unsigned SATURATE     = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               done_in,
    input  logic [NUM_EVENTS-1:0]              event_valid,
    input  logic [NUM_EVENTS*WEIGHT_WIDTH-1:0] event_weight,
    input  logic                               snap_req,
    input  logic [clog2(NUM_EVENTS+2)-1:0]     rd_sel,
    output logic [CNT_WIDTH-1:0]               rd_data,
    output logic [CNT_WIDTH-1:0]               num_inst,
    output logic [CNT_WIDTH-1:0]               num_total,
    output logic [NUM_EVENTS*CNT_WIDTH-1:0]    event_counts,
    output logic                               done,
    output logic                               overflow
);

    localparam int unsigned NUM_CNT   = NUM_EVENTS + 2;
    localparam int unsigned SEL_WIDTH = clog2(NUM_EVENTS + 2);
    localparam int unsigned TW        = CNT_WIDTH + clog2(NUM_EVENTS) + WEIGHT_WIDTH;

    localparam logic [SEL_WIDTH-1:0] LAST_SEL  = SEL_WIDTH'(NUM_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_VAL = CNT_WIDTH'(DRAIN_ADJ);

    pm_state_e state_q, state_d;
    logic      done_q;

    logic [NUM_CNT-1:0][TW-1:0]        cnt_inc;
    logic [NUM_CNT-1:0]                cnt_en;
    logic [NUM_CNT-1:0]                cnt_load;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_val;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_next;
    logic [NUM_CNT-1:0]                cnt_ovf;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] shadow_q;
    logic [CNT_WIDTH-1:0]              rd_data_q;
    logic [CNT_WIDTH-1:0]              inst_load_val;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = PM_RUN;
        end else begin
            unique case (state_q)
                PM_RUN:   if (done_in) state_d = PM_DRAIN;
                PM_DRAIN: state_d = PM_DONE;
                PM_DONE:  state_d = PM_DONE;
                default:  state_d = PM_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= PM_RUN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == PM_DONE);
        end
    end

    // Instruction ticks stop at completion; channels keep counting through DRAIN.
    always_comb begin
        logic          run;
        logic          counting;
        logic [TW-1:0] w;
        logic [TW-1:0] total_inc;
        cnt_inc   = '0;
        cnt_en    = '0;
        cnt_load  = '0;
        total_inc = '0;
        w         = '0;
        run       = (state_q == PM_RUN);
        counting  = run || (state_q == PM_DRAIN);

        inst_load_val = (cnt_val[SEL_INST] >= DRAIN_VAL) ? cnt_val[SEL_INST] - DRAIN_VAL : '0;
        cnt_inc[SEL_INST]  = TW'(1);
        cnt_en[SEL_INST]   = run && !done_in;
        cnt_load[SEL_INST] = run && done_in;

        for (int k = 0; k < NUM_EVENTS; k++) begin
            if (event_valid[k]) begin
                w                        = TW'(event_weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
                cnt_inc[SEL_EV_BASE + k] = w;
                total_inc                = total_inc + w;
            end
            cnt_en[SEL_EV_BASE + k] = counting;
        end
        cnt_inc[SEL_TOTAL] = total_inc;
        cnt_en[SEL_TOTAL]  = counting;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        perf_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (TW),
            .SATURATE  (SATURATE)
        ) u_counter (
            .clock      (clock),
            .reset      (reset),
            .clear      (clear),
            .enable     (cnt_en[i]),
            .inc        (cnt_inc[i]),
            .load       (cnt_load[i]),
            .load_val   ((i == SEL_INST) ? inst_load_val : '0),
            .count      (cnt_val[i]),
            .count_next (cnt_next[i]),
            .overflow   (cnt_ovf[i])
        );
    end

    // Shadows capture the post-update value of the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_q  <= '0;
            rd_data_q <= '0;
        end else if (clear) begin
            shadow_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (snap_req) begin
                shadow_q <= cnt_next;
            end
            rd_data_q <= (rd_sel <= LAST_SEL) ? shadow_q[rd_sel] : '0;
        end
    end

    assign rd_data      = rd_data_q;
    assign num_inst     = cnt_val[SEL_INST];
    assign num_total    = cnt_val[SEL_TOTAL];
    assign event_counts = cnt_val[NUM_CNT-1:SEL_EV_BASE];
    assign done         = done_q;
    assign overflow     = |cnt_ovf;

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a 32-bit saturating instance plus 8-bit saturating
// and wrapping instances on shared stimulus, checked against an arithmetic model.
module tb_perf_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        done_in = 1'b0;
    logic        snap_req = 1'b0;
    logic [3:0]  event_valid = '0;
    logic [11:0] event_weight = '0;
    logic [2:0]  rd_sel = '0;

    logic [31:0]  rd0, inst0, tot0;
    logic [127:0] ev0;
    logic         done0, ovf0;
    logic [7:0]   rd1, inst1, tot1, rd2, inst2, tot2;
    logic [31:0]  ev1, ev2;
    logic         done1, ovf1, done2, ovf2;

    perf_monitor #(
        .NUM_EVENTS(4), .CNT_WIDTH(32), .WEIGHT_WIDTH(3), .DRAIN_ADJ(4), .SATURATE(1)
    ) u_dut (
        .clock(clock), .reset(reset), .clear(clear), .done_in(done_in),
        .event_valid(event_valid), .event_weight(event_weight), .snap_req(snap_req),
        .rd_sel(rd_sel), .rd_data(rd0), .num_inst(inst0), .num_total(tot0),
        .event_counts(ev0), .done(done0), .overflow(ovf0)
    );

    perf_monitor #(
        .NUM_EVENTS(4), .CNT_WIDTH(8), .WEIGHT_WIDTH(3), .DRAIN_ADJ(4), .SATURATE(1)
    ) u_sat8 (
        .clock(clock), .reset(reset), .clear(clear), .done_in(done_in),
        .event_valid(event_valid), .event_weight(event_weight), .snap_req(snap_req),
        .rd_sel(rd_sel), .rd_data(rd1), .num_inst(inst1), .num_total(tot1),
        .event_counts(ev1), .done(done1), .overflow(ovf1)
    );

    perf_monitor #(
        .NUM_EVENTS(4), .CNT_WIDTH(8), .WEIGHT_WIDTH(3), .DRAIN_ADJ(4), .SATURATE(0)
    ) u_wrap8 (
        .clock(clock), .reset(reset), .clear(clear), .done_in(done_in),
        .event_valid(event_valid), .event_weight(event_weight), .snap_req(snap_req),
        .rd_sel(rd_sel), .rd_data(rd2), .num_inst(inst2), .num_total(tot2),
        .event_counts(ev2), .done(done2), .overflow(ovf2)
    );

    always #5 clock = ~clock;

    // Model state per instance; index 0 = instructions, 1 = total, 2+k = channel k.
    int unsigned cw [3] = '{32, 8, 8};
    bit          csat [3] = '{1'b1, 1'b1, 1'b0};
    longint      m_cnt [3][6];
    longint      m_sh [3][6];
    longint      m_rd [3];
    bit          m_ovf [3];
    bit          m_done [3];
    int          m_ph [3];  // 0 running, 1 draining, 2 finished

    int n_checks = 0;
    int n_pass = 0;

    function automatic logic [63:0] act_cnt(input int c, input int i);
        logic [63:0] r;
        r = '0;
        if (c == 0) begin
            if (i == 0) r = 64'(inst0);
            else if (i == 1) r = 64'(tot0);
            else r = 64'(ev0[(i-2)*32 +: 32]);
        end else if (c == 1) begin
            if (i == 0) r = 64'(inst1);
            else if (i == 1) r = 64'(tot1);
            else r = 64'(ev1[(i-2)*8 +: 8]);
        end else begin
            if (i == 0) r = 64'(inst2);
            else if (i == 1) r = 64'(tot2);
            else r = 64'(ev2[(i-2)*8 +: 8]);
        end
        return r;
    endfunction

    function automatic logic [63:0] act_rd(input int c);
        return (c == 0) ? 64'(rd0) : (c == 1) ? 64'(rd1) : 64'(rd2);
    endfunction

    function automatic logic [1:0] act_flags(input int c);
        return (c == 0) ? {done0, ovf0} : (c == 1) ? {done1, ovf1} : {done2, ovf2};
    endfunction

    function automatic longint m_add(input longint v, input longint inc, input longint limit,
                                     input bit sat, inout bit ovf);
        longint s;
        s = v + inc;
        if (s > limit) begin
            ovf = 1'b1;
            return sat ? limit : (s & limit);
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 6; i++) begin
                m_cnt[c][i] = 0;
                m_sh[c][i]  = 0;
            end
            m_rd[c] = 0; m_ovf[c] = 0; m_done[c] = 0; m_ph[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            longint nc [6];
            longint limit;
            longint sum;
            int     ph_n;
            if (clear) begin
                for (int i = 0; i < 6; i++) begin
                    m_cnt[c][i] = 0;
                    m_sh[c][i]  = 0;
                end
                m_rd[c] = 0; m_ovf[c] = 0; m_done[c] = 0; m_ph[c] = 0;
            end else begin
                limit = (64'sd1 <<< cw[c]) - 1;
                for (int i = 0; i < 6; i++) nc[i] = m_cnt[c][i];
                m_rd[c] = (rd_sel <= 3'd5) ? m_sh[c][rd_sel] : 0;
                if (m_ph[c] == 0) begin
                    if (done_in) nc[0] = (nc[0] >= 4) ? nc[0] - 4 : 0;
                    else nc[0] = m_add(nc[0], 1, limit, csat[c], m_ovf[c]);
                end
                if (m_ph[c] <= 1) begin
                    sum = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (event_valid[k]) begin
                            nc[2+k] = m_add(nc[2+k], longint'(event_weight[k*3 +: 3]), limit,
                                            csat[c], m_ovf[c]);
                            sum += longint'(event_weight[k*3 +: 3]);
                        end
                    end
                    nc[1] = m_add(nc[1], sum, limit, csat[c], m_ovf[c]);
                end
                ph_n = (m_ph[c] == 0) ? (done_in ? 1 : 0) : 2;
                m_ph[c]   = ph_n;
                m_done[c] = (ph_n == 2);
                for (int i = 0; i < 6; i++) begin
                    if (snap_req) m_sh[c][i] = nc[i];
                    m_cnt[c][i] = nc[i];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic set_idle();
        clear = 0; done_in = 0; snap_req = 0; event_valid = '0; event_weight = '0; rd_sel = '0;
    endtask

    task automatic rand_events();
        event_valid  = 4'($urandom);
        event_weight = 12'($urandom);
    endtask

    task automatic do_clear();
        set_idle();
        clear = 1;
        tick();
        clear = 0;
    endtask

    task automatic test_reset();
        set_idle();
        #1 reset = 0;
        #2;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (act_cnt(c, i) !== 64'd0)
                    $display("FAIL reset_cnt c%0d i%0d got %0d want 0", c, i, act_cnt(c, i));
                else n_pass++;
            end
            n_checks++;
            if ({act_rd(c), act_flags(c)} !== 66'd0)
                $display("FAIL reset_rd_flags c%0d got rd=%0d flags=%b want 0", c, act_rd(c),
                         act_flags(c));
            else n_pass++;
        end
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1;
        repeat (10) tick();
        n_checks++;
        if (inst0 !== 32'd10) $display("FAIL idle_inst got %0d want 10", inst0);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (act_cnt(c, i) !== 64'(m_cnt[c][i]))
                    $display("FAIL idle_cnt c%0d i%0d got %0d want %0d", c, i, act_cnt(c, i),
                             m_cnt[c][i]);
                else n_pass++;
            end
            n_checks++;
            if (act_flags(c) !== 2'b00)
                $display("FAIL idle_flags c%0d got %b want 00", c, act_flags(c));
            else n_pass++;
        end
    endtask

    task automatic test_events();
        do_clear();
        event_valid  = 4'b0101;
        event_weight = {3'd0, 3'd2, 3'd0, 3'd1};
        repeat (5) tick();
        n_checks++;
        if ({ev0[31:0], ev0[95:64], tot0} !== {32'd5, 32'd10, 32'd15})
            $display("FAIL two_channels got ch0=%0d ch2=%0d tot=%0d want 5 10 15", ev0[31:0],
                     ev0[95:64], tot0);
        else n_pass++;
        repeat (30) begin
            rand_events();
            tick();
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < 6; i++) begin
                    n_checks++;
                    if (act_cnt(c, i) !== 64'(m_cnt[c][i]))
                        $display("FAIL rand_events c%0d i%0d got %0d want %0d", c, i,
                                 act_cnt(c, i), m_cnt[c][i]);
                    else n_pass++;
                end
            end
        end
        set_idle();
    endtask

    task automatic test_saturate();
        do_clear();
        event_valid  = 4'b0010;
        event_weight = 12'd7 << 3;
        repeat (40) tick();
        n_checks++;
        if ({ev1[15:8], ovf1} !== {8'd255, 1'b1})
            $display("FAIL sat8_ch1 got %0d ovf=%b want 255 ovf=1", ev1[15:8], ovf1);
        else n_pass++;
        n_checks++;
        if ({ev2[15:8], ovf2} !== {8'd24, 1'b1})
            $display("FAIL wrap8_ch1 got %0d ovf=%b want 24 ovf=1", ev2[15:8], ovf2);
        else n_pass++;
        n_checks++;
        if ({ev0[63:32], ovf0} !== {32'd280, 1'b0})
            $display("FAIL wide_ch1 got %0d ovf=%b want 280 ovf=0", ev0[63:32], ovf0);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_snapshot();
        do_clear();
        repeat (6) tick();
        snap_req = 1;
        tick();
        snap_req = 0;
        repeat (4) tick();
        rd_sel = 3'd0;
        tick();
        n_checks++;
        if ({inst0, rd0} !== {32'd12, 32'd7})
            $display("FAIL snap_inst got inst=%0d rd=%0d want 12 7", inst0, rd0);
        else n_pass++;
        rd_sel = 3'd6;
        tick();
        n_checks++;
        if (rd0 !== 32'd0) $display("FAIL rd_out_of_range got %0d want 0", rd0);
        else n_pass++;
        repeat (30) begin
            rand_events();
            snap_req = ($urandom_range(0, 3) == 0);
            rd_sel   = 3'($urandom);
            tick();
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (act_rd(c) !== 64'(m_rd[c]))
                    $display("FAIL rand_readout c%0d got %0d want %0d", c, act_rd(c), m_rd[c]);
                else n_pass++;
            end
        end
        set_idle();
    endtask

    task automatic test_done();
        longint frozen [6];
        do_clear();
        repeat (20) tick();
        done_in = 1;
        rand_events();
        tick();
        n_checks++;
        if ({inst0, done0} !== {32'd16, 1'b0})
            $display("FAIL drain_adj got inst=%0d done=%b want 16 0", inst0, done0);
        else n_pass++;
        done_in = 0;
        rand_events();
        tick();
        n_checks++;
        if (done0 !== 1'b1) $display("FAIL done_rise got %b want 1", done0);
        else n_pass++;
        for (int i = 0; i < 6; i++) frozen[i] = m_cnt[0][i];
        repeat (10) begin
            rand_events();
            done_in = 1'($urandom);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (act_cnt(0, i) !== 64'(frozen[i]))
                $display("FAIL frozen i%0d got %0d want %0d", i, act_cnt(0, i), frozen[i]);
            else n_pass++;
        end
        n_checks++;
        if (done0 !== 1'b1) $display("FAIL done_hold got %b want 1", done0);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_async_reset();
        do_clear();
        repeat (8) begin
            rand_events();
            tick();
        end
        done_in = 1;
        tick();
        done_in = 0;
        rand_events();
        #2 reset = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (act_cnt(c, i) !== 64'd0)
                    $display("FAIL async_reset c%0d i%0d got %0d want 0", c, i, act_cnt(c, i));
                else n_pass++;
            end
            n_checks++;
            if ({act_rd(c), act_flags(c)} !== 66'd0)
                $display("FAIL async_reset_flags c%0d got rd=%0d flags=%b want 0", c, act_rd(c),
                         act_flags(c));
            else n_pass++;
        end
        model_reset();
        set_idle();
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_clear_done();
        do_clear();
        repeat (3) tick();
        done_in = 1;
        tick();
        done_in = 0;
        tick();
        n_checks++;
        if (done0 !== 1'b1) $display("FAIL reach_done got %b want 1", done0);
        else n_pass++;
        clear = 1;
        tick();
        clear = 0;
        n_checks++;
        if ({done0, inst0, tot0} !== 65'd0)
            $display("FAIL clear_in_done got done=%b inst=%0d tot=%0d want 0", done0, inst0,
                     tot0);
        else n_pass++;
        tick();
        n_checks++;
        if (inst0 !== 32'd1) $display("FAIL run_after_clear got %0d want 1", inst0);
        else n_pass++;
    endtask

    task automatic test_random();
        repeat (400) begin
            rand_events();
            clear    = ($urandom_range(0, 39) == 0);
            done_in  = ($urandom_range(0, 24) == 0);
            snap_req = ($urandom_range(0, 4) == 0);
            rd_sel   = 3'($urandom);
            tick();
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < 6; i++) begin
                    n_checks++;
                    if (act_cnt(c, i) !== 64'(m_cnt[c][i]))
                        $display("FAIL random_cnt c%0d i%0d got %0d want %0d", c, i,
                                 act_cnt(c, i), m_cnt[c][i]);
                    else n_pass++;
                end
                n_checks++;
                if (act_rd(c) !== 64'(m_rd[c]))
                    $display("FAIL random_rd c%0d got %0d want %0d", c, act_rd(c), m_rd[c]);
                else n_pass++;
                n_checks++;
                if (act_flags(c) !== {m_done[c], m_ovf[c]})
                    $display("FAIL random_flags c%0d got %b want %b", c, act_flags(c),
                             {m_done[c], m_ovf[c]});
                else n_pass++;
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_events();
        test_saturate();
        test_snapshot();
        test_done();
        test_async_reset();
        test_clear_done();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got no finish want finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/perf_monitor.md
Name: perf_monitor

Overview:
- Parametrised pipeline performance monitor for the processor test harness.
- Counts retired-cycle/instruction ticks plus NUM_EVENTS weighted event channels (stall, FD flush, DX flush, mispredict, ...).
- Freezes on program completion with a drain correction, and adds a snapshot/readout port for debug muxing.
- Simultaneous events on different channels are all counted; none are lost.

Parameters:
- NUM_EVENTS, 4, number of event channels.
- CNT_WIDTH, 32, width of every counter.
- WEIGHT_WIDTH, 3, width of each per-channel increment weight.
- DRAIN_ADJ, 4, value subtracted from the instruction counter when done is detected (pipeline bubbles behind last instruction).
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap modulo 2^CNT_WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of all counters and state; highest priority after reset.
- done_in  input  1  program-complete indication (level, e.g. debug register == 1).
- event_valid  input  NUM_EVENTS  per-channel event strobe for this cycle.
- event_weight  input  NUM_EVENTS*WEIGHT_WIDTH  per-channel increment, channel k in bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- snap_req  input  1  latch all live counters into shadow registers.
- rd_sel  input  clog2(NUM_EVENTS+2)  readout select: 0 = instructions, 1 = total events, 2+k = channel k.
- rd_data  output  CNT_WIDTH  registered shadow value selected by rd_sel.
- num_inst  output  CNT_WIDTH  live instruction counter.
- num_total  output  CNT_WIDTH  live sum of all channel increments.
- event_counts  output  NUM_EVENTS*CNT_WIDTH  live per-channel counters, same packing as event_weight.
- done  output  1  high once in DONE state.
- overflow  output  1  sticky: any counter saturated or wrapped.

Behaviour:
- Reset (reset low, async):
  - all counters, shadows, rd_data, done and overflow go to 0.
  - state goes to RUN.
- clear=1: same effect as reset, applied on the next rising edge; overrides every other input that cycle.
- State machine:
  - RUN -> DRAIN on done_in=1.
  - DRAIN -> DONE unconditionally after one cycle.
  - DONE holds until clear or reset; done_in deasserting has no effect.
- RUN:
  - num_inst += 1 every cycle.
  - For each k with event_valid[k]=1, channel k += event_weight[k]; weight 0 is legal and adds nothing.
  - num_total += sum of all valid weights this cycle, computed at CNT_WIDTH+clog2(NUM_EVENTS)+WEIGHT_WIDTH width before saturate/wrap.
- Cycle in which done_in is first seen in RUN:
  - num_inst -= DRAIN_ADJ instead of +1, clamped at 0 regardless of SATURATE.
  - Event counting still occurs.
- DRAIN: event channels and num_total still count (in-flight flushes); num_inst holds.
- DONE: all counters frozen; done=1 (registered, first high the cycle after DRAIN).
- Overflow:
  - SATURATE=1: an increment exceeding all-ones holds all-ones and sets overflow.
  - SATURATE=0: the counter wraps and sets overflow.
  - overflow clears only on reset or clear.
- Snapshot:
  - snap_req=1 latches the post-update values of the same edge into shadows.
  - Shadows hold until the next snap_req, clear or reset.
  - snap_req during clear latches zeros.
- Readout:
  - rd_data = shadow[rd_sel], registered, 1-cycle latency.
  - rd_sel beyond NUM_EVENTS+1 returns 0.
- Reset asserted mid-operation (any state) returns immediately to reset values.

Decomposition:
- Shared package perf_pkg:
  - state encoding (PM_RUN, PM_DRAIN, PM_DONE).
  - readout select constants (SEL_INST=0, SEL_TOTAL=1, SEL_EV_BASE=2).
  - clog2 helper.
- One sub-module, perf_counter: a single CNT_WIDTH counter with enable, increment input, hold, clear and a SATURATE/wrap overflow flag.
- perf_counter is instantiated NUM_EVENTS+2 times via generate.

Test Plan:
- Reset release, 10 idle cycles, done_in=0 -> num_inst=10, all events 0, done=0, overflow=0.
- Channels 0 and 2 valid every cycle with weights 1 and 2 for 5 cycles -> ch0=5, ch2=10, num_total=15; no lost counts.
- 20 cycles of RUN, then done_in=1 -> num_inst=20-4=16; done=1 two edges later; further events and cycles leave all counters unchanged.
- CNT_WIDTH=8, SATURATE=1, ch1 weight 7 for 40 cycles -> ch1=255, overflow=1. Repeat with SATURATE=0 -> ch1=(280 mod 256)=24, overflow=1.
- snap_req at num_inst=7, run 5 more cycles, rd_sel=0 -> rd_data=7 one cycle after select while num_inst=12. rd_sel=NUM_EVENTS+2 -> rd_data=0.
- reset low asynchronously mid-DRAIN -> all outputs 0 immediately. clear pulse in DONE -> RUN, counters 0, done=0 next edge.
